branch_control: RTL and testbench

- Branch/jump resolution stage that sits directly upstream of the program counter and drives its set_addr/in_addr load port.
- Consumes each instruction as it leaves instruction memory, together with the address it was fetched from and the current PSR flags.
- Evaluates Bcond, Jcond and JAL. On a taken transfer it issues a one-cycle PC load, then asserts flush for a fixed number of cycles so that wrong-path instructions, already fetched because the PC keeps incrementing, are discarded.

---
 rtl/branch_control_if.sv | 48 ++++
 rtl/branch_control.sv | 166 ++++++++++++++++
 tb/tb_branch_control.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_control_if.sv
// -----------------------------------------------------------------------------
// branch_control_if
//   Connects the fetch side and the PC load port to branch_control.
//   Handshake: there is no back-pressure. instr_valid qualifies instr,
//   instr_pc, the PSR flags and rtarget_data in the same cycle, and a beat is
//   consumed whenever instr_valid is high. set_addr is a one-cycle strobe that
//   qualifies in_addr. link_we is a one-cycle strobe that qualifies link_sel
//   and link_data. flush marks the instruction presented in that cycle as
//   invalid.
//
//   Signals (direction as seen by the branch_control slave):
//     instr_valid, instr[15:0], instr_pc[ADDR_W-1:0]        in
//     flag_c, flag_l, flag_f, flag_z, flag_n                in
//     rtarget_data[15:0]                                    in
//     set_addr, in_addr[ADDR_W-1:0], flush                  out
//     link_we, link_sel[3:0], link_data[ADDR_W-1:0]         out
// -----------------------------------------------------------------------------
interface branch_control_if #(
    parameter int ADDR_W = 15
);
    logic              instr_valid;
    logic [15:0]       instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              flag_c;
    logic              flag_l;
    logic              flag_f;
    logic              flag_z;
    logic              flag_n;
    logic [15:0]       rtarget_data;
    logic              set_addr;
    logic [ADDR_W-1:0] in_addr;
    logic              flush;
    logic              link_we;
    logic [3:0]        link_sel;
    logic [ADDR_W-1:0] link_data;

    modport master (
        output instr_valid, instr, instr_pc,
        output flag_c, flag_l, flag_f, flag_z, flag_n, rtarget_data,
        input  set_addr, in_addr, flush, link_we, link_sel, link_data
    );

    modport slave (
        input  instr_valid, instr, instr_pc,
        input  flag_c, flag_l, flag_f, flag_z, flag_n, rtarget_data,
        output set_addr, in_addr, flush, link_we, link_sel, link_data
    );
endinterface

// File: rtl/branch_control.sv
// -----------------------------------------------------------------------------
// branch_control
//   Resolves Bcond / Jcond / JAL for the instruction leaving instruction
//   memory. A taken transfer in cycle N produces a one-cycle PC load
//   (set_addr/in_addr) in cycle N+1, with flush held high from N+1 for
//   1 + FLUSH_CYCLES cycles so wrong-path fetches are discarded. JAL also
//   pulses link_we in N+1 with the return address instr_pc + 1.
//
//   Ports:
//     CLK          clock, rising edge
//     CLR_N        asynchronous active-low reset
//     bus          branch_control_if.slave (instruction in, PC load/link out)
//     dbg_state    current FSM state (0 RUN, 1 REDIRECT, 2 FLUSH)
//     stats_clr    synchronous clear of taken_count   (BRANCH_STATS_EN only)
//     taken_count  saturating count of redirects      (BRANCH_STATS_EN only)
//
//   Optional feature macro: BRANCH_STATS_EN
// -----------------------------------------------------------------------------
module branch_control #(
    parameter int FLUSH_CYCLES = 2,
    parameter int ADDR_W       = 15
) (
    input  logic                  CLK,
    input  logic                  CLR_N,
`ifdef BRANCH_STATS_EN
    input  logic                  stats_clr,
    output logic [15:0]           taken_count,
`endif
    output logic [1:0]            dbg_state,
    branch_control_if.slave       bus
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    state_t            state;
    logic [2:0]        flush_cnt;
    logic              set_addr_q;
    logic [ADDR_W-1:0] in_addr_q;
    logic              flush_q;
    logic              link_we_q;
    logic [3:0]        link_sel_q;
    logic [ADDR_W-1:0] link_data_q;

    // Decode
    logic              is_bcond;
    logic              is_jcond;
    logic              is_jal;
    logic              cond_true;
    logic              taken;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] disp_ext;

    assign is_bcond = (bus.instr[15:12] == 4'b1100);
    assign is_jcond = (bus.instr[15:12] == 4'b0100) && (bus.instr[7:4] == 4'b1100);
    assign is_jal   = (bus.instr[15:12] == 4'b0100) && (bus.instr[7:4] == 4'b1000);
    assign disp_ext = {{(ADDR_W-8){bus.instr[7]}}, bus.instr[7:0]};

    always_comb begin
        cond_true = 1'b0;
        case (bus.instr[11:8])
            4'h0: cond_true = bus.flag_z;
            4'h1: cond_true = !bus.flag_z;
            4'h2: cond_true = bus.flag_c;
            4'h3: cond_true = !bus.flag_c;
            4'h4: cond_true = bus.flag_l;
            4'h5: cond_true = !bus.flag_l;
            4'h6: cond_true = bus.flag_n;
            4'h7: cond_true = !bus.flag_n;
            4'h8: cond_true = bus.flag_f;
            4'h9: cond_true = !bus.flag_f;
            4'hA: cond_true = !bus.flag_l && !bus.flag_z;
            4'hB: cond_true = bus.flag_l || bus.flag_z;
            4'hC: cond_true = !bus.flag_n && !bus.flag_z;
            4'hD: cond_true = bus.flag_n || bus.flag_z;
            4'hE: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    assign taken  = is_jal || ((is_bcond || is_jcond) && cond_true);
    // Register targets drop bit 15 of the register value.
    assign target = is_bcond ? (bus.instr_pc + disp_ext) : bus.rtarget_data[ADDR_W-1:0];

    // Rtarget index and the dropped register bit are not needed here.
    logic unused_bits;
    assign unused_bits = ^{bus.instr[3:0], bus.rtarget_data[15]};

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state       <= RUN;
            flush_cnt   <= 3'd0;
            set_addr_q  <= 1'b0;
            in_addr_q   <= '0;
            flush_q     <= 1'b0;
            link_we_q   <= 1'b0;
            link_sel_q  <= 4'h0;
            link_data_q <= '0;
        end else begin
            case (state)
                RUN: begin
                    set_addr_q <= 1'b0;
                    link_we_q  <= 1'b0;
                    flush_q    <= 1'b0;
                    if (bus.instr_valid && taken) begin
                        // Outputs are registered, so the strobes for the
                        // REDIRECT cycle are set on the way into it.
                        in_addr_q  <= target;
                        set_addr_q <= 1'b1;
                        flush_q    <= 1'b1;
                        link_we_q  <= is_jal;
                        if (is_jal) begin
                            link_sel_q  <= bus.instr[11:8];
                            link_data_q <= bus.instr_pc + ADDR_W'(1);
                        end
                        state <= REDIRECT;
                    end
                end
                REDIRECT: begin
                    set_addr_q <= 1'b0;
                    link_we_q  <= 1'b0;
                    flush_q    <= 1'b1;
                    flush_cnt  <= 3'(FLUSH_CYCLES);
                    state      <= FLUSH;
                end
                FLUSH: begin
                    if (flush_cnt == 3'd1) begin
                        flush_q   <= 1'b0;
                        flush_cnt <= 3'd0;
                        state     <= RUN;
                    end else begin
                        flush_cnt <= flush_cnt - 3'd1;
                    end
                end
                default: begin
                    state   <= RUN;
                    flush_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            taken_count <= 16'h0000;
        end else if (stats_clr) begin
            taken_count <= 16'h0000;
        end else if (state == RUN && bus.instr_valid && taken && taken_count != 16'hFFFF) begin
            taken_count <= taken_count + 16'h0001;
        end
    end
`endif

    assign dbg_state     = state;
    assign bus.set_addr  = set_addr_q;
    assign bus.in_addr   = in_addr_q;
    assign bus.flush     = flush_q;
    assign bus.link_we   = link_we_q;
    assign bus.link_sel  = link_sel_q;
    assign bus.link_data = link_data_q;

endmodule

// File: tb/tb_branch_control.sv
module tb_branch_control;

    logic        CLK;
    logic        CLR_N;
    logic [1:0]  dbg_state;
`ifdef BRANCH_STATS_EN
    logic        stats_clr;
    logic [15:0] taken_count;
`endif

    int checks = 0;
    int errors = 0;

    branch_control_if #(.ADDR_W(15)) bus ();

    branch_control #(.FLUSH_CYCLES(2), .ADDR_W(15)) dut (
        .CLK        (CLK),
        .CLR_N      (CLR_N),
`ifdef BRANCH_STATS_EN
        .stats_clr  (stats_clr),
        .taken_count(taken_count),
`endif
        .dbg_state  (dbg_state),
        .bus        (bus)
    );

    // Clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Driver tasks: inputs change on the falling edge, outputs are sampled on
    // the following falling edge (one rising edge later).
    task automatic step();
        @(negedge CLK);
    endtask

    // f = {c, l, f, z, n}
    task automatic drive(input logic v, input logic [15:0] i, input logic [14:0] pc,
                         input logic [15:0] rt, input logic [4:0] f);
        bus.instr_valid  = v;
        bus.instr        = i;
        bus.instr_pc     = pc;
        bus.rtarget_data = rt;
        bus.flag_c       = f[4];
        bus.flag_l       = f[3];
        bus.flag_f       = f[2];
        bus.flag_z       = f[1];
        bus.flag_n       = f[0];
    endtask

    task automatic idle();
        drive(1'b0, 16'h0000, 15'h0000, 16'h0000, 5'b00000);
    endtask

    task automatic test_reset();
        CLR_N = 1'b0;
        idle();
`ifdef BRANCH_STATS_EN
        stats_clr = 1'b0;
`endif
        step();
        step();
        checks++;
        if ({bus.set_addr, bus.flush, bus.link_we} !== 3'b000) begin
            errors++;
            $display("FAIL reset_strobes got %b exp 000", {bus.set_addr, bus.flush, bus.link_we});
        end
        checks++;
        if ({bus.in_addr, bus.link_sel, bus.link_data} !== 34'h0) begin
            errors++;
            $display("FAIL reset_fields got %h exp 0", {bus.in_addr, bus.link_sel, bus.link_data});
        end
`ifdef BRANCH_STATS_EN
        checks++;
        if (taken_count !== 16'h0000) begin
            errors++;
            $display("FAIL reset_taken_count got %h exp 0000", taken_count);
        end
`endif
        CLR_N = 1'b1;
        step();
        checks++;
        if (dbg_state !== 2'd0 || bus.set_addr !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got state %0d set_addr %b exp 0 0", dbg_state, bus.set_addr);
        end
    endtask

    task automatic test_beq_taken();
        drive(1'b1, 16'hC0FE, 15'h0010, 16'h0000, 5'b00010);
        step();
        idle();
        checks++;
        if (bus.set_addr !== 1'b1 || bus.in_addr !== 15'h000E) begin
            errors++;
            $display("FAIL beq_redirect got set_addr %b in_addr %h exp 1 000e", bus.set_addr, bus.in_addr);
        end
        checks++;
        if (bus.flush !== 1'b1 || bus.link_we !== 1'b0) begin
            errors++;
            $display("FAIL beq_n1_flush got flush %b link_we %b exp 1 0", bus.flush, bus.link_we);
        end
        step();
        checks++;
        if (bus.set_addr !== 1'b0 || bus.flush !== 1'b1) begin
            errors++;
            $display("FAIL beq_n2 got set_addr %b flush %b exp 0 1", bus.set_addr, bus.flush);
        end
        step();
        checks++;
        if (bus.flush !== 1'b1) begin
            errors++;
            $display("FAIL beq_n3_flush got %b exp 1", bus.flush);
        end
        step();
        checks++;
        if (bus.flush !== 1'b0 || bus.in_addr !== 15'h000E) begin
            errors++;
            $display("FAIL beq_n4 got flush %b in_addr %h exp 0 000e", bus.flush, bus.in_addr);
        end
    endtask

    task automatic test_beq_not_taken();
        drive(1'b1, 16'hC0FE, 15'h0010, 16'h0000, 5'b00000);
        for (int k = 0; k < 2; k++) begin
            step();
            idle();
            checks++;
            if ({bus.set_addr, bus.flush, bus.link_we} !== 3'b000) begin
                errors++;
                $display("FAIL beq_not_taken cyc %0d got %b exp 000", k, {bus.set_addr, bus.flush, bus.link_we});
            end
        end
    endtask

    task automatic test_wrap();
        drive(1'b1, 16'hCE05, 15'h7FFE, 16'h0000, 5'b00000);
        step();
        idle();
        checks++;
        if (bus.set_addr !== 1'b1 || bus.in_addr !== 15'h0003) begin
            errors++;
            $display("FAIL wrap got set_addr %b in_addr %h exp 1 0003", bus.set_addr, bus.in_addr);
        end
        step();
        step();
        step();
        checks++;
        if (bus.flush !== 1'b0) begin
            errors++;
            $display("FAIL wrap_flush_end got %b exp 0", bus.flush);
        end
    endtask

    task automatic test_jal();
        drive(1'b1, 16'h4E83, 15'h0040, 16'h8123, 5'b00000);
        step();
        idle();
        checks++;
        if (bus.set_addr !== 1'b1 || bus.in_addr !== 15'h0123) begin
            errors++;
            $display("FAIL jal_target got set_addr %b in_addr %h exp 1 0123", bus.set_addr, bus.in_addr);
        end
        checks++;
        if (bus.link_we !== 1'b1 || bus.link_sel !== 4'hE || bus.link_data !== 15'h0041) begin
            errors++;
            $display("FAIL jal_link got we %b sel %h data %h exp 1 e 0041", bus.link_we, bus.link_sel, bus.link_data);
        end
        step();
        checks++;
        if (bus.link_we !== 1'b0 || bus.set_addr !== 1'b0) begin
            errors++;
            $display("FAIL jal_pulse_width got we %b set_addr %b exp 0 0", bus.link_we, bus.set_addr);
        end
        step();
        step();
    endtask

    typedef struct {
        logic [3:0] cond;
        logic [4:0] flags;   // {c, l, f, z, n}
        logic       exp;
    } cond_vec_t;

    task automatic test_conditions();
        cond_vec_t vecs[8];
        vecs[0] = '{4'hA, 5'b00000, 1'b1};  // LO, !L & !Z
        vecs[1] = '{4'hA, 5'b01000, 1'b0};  // LO with L set
        vecs[2] = '{4'hB, 5'b00010, 1'b1};  // HS via Z
        vecs[3] = '{4'hC, 5'b00000, 1'b1};  // LT, !N & !Z
        vecs[4] = '{4'hD, 5'b00000, 1'b0};  // GE, N=0 Z=0
        vecs[5] = '{4'hF, 5'b11111, 1'b0};  // never
        vecs[6] = '{4'h2, 5'b10000, 1'b1};  // CS
        vecs[7] = '{4'h9, 5'b00100, 1'b0};  // FC with F set
        for (int v = 0; v < 8; v++) begin
            drive(1'b1, {4'hC, vecs[v].cond, 8'h01}, 15'h0100, 16'h0000, vecs[v].flags);
            step();
            idle();
            checks++;
            if (bus.set_addr !== vecs[v].exp) begin
                errors++;
                $display("FAIL cond_%0h got set_addr %b exp %b", vecs[v].cond, bus.set_addr, vecs[v].exp);
            end
            if (vecs[v].exp) begin
                checks++;
                if (bus.in_addr !== 15'h0101) begin
                    errors++;
                    $display("FAIL cond_%0h_target got %h exp 0101", vecs[v].cond, bus.in_addr);
                end
            end
            step();
            step();
            step();
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses = 0;
`ifdef BRANCH_STATS_EN
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        checks++;
        if (taken_count !== 16'h0000) begin
            errors++;
            $display("FAIL stats_clr got %h exp 0000", taken_count);
        end
`endif
        drive(1'b1, 16'hC0FE, 15'h0010, 16'h0000, 5'b00010);
        step();
        if (bus.set_addr === 1'b1) pulses++;
        drive(1'b1, 16'h4EC5, 15'h0011, 16'h0200, 5'b00000);
        step();
        if (bus.set_addr === 1'b1) pulses++;
        drive(1'b1, 16'h4EC5, 15'h0012, 16'h0200, 5'b00000);
        step();
        if (bus.set_addr === 1'b1) pulses++;
        idle();
        for (int k = 0; k < 5; k++) begin
            step();
            if (bus.set_addr === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL mask_pulses got %0d exp 1", pulses);
        end
        checks++;
        if (bus.in_addr !== 15'h000E) begin
            errors++;
            $display("FAIL mask_target got %h exp 000e", bus.in_addr);
        end
`ifdef BRANCH_STATS_EN
        checks++;
        if (taken_count !== 16'h0001) begin
            errors++;
            $display("FAIL mask_taken_count got %h exp 0001", taken_count);
        end
`endif
        // Once the flush window is over a new taken jump acts again.
        drive(1'b1, 16'h4EC5, 15'h0020, 16'h0200, 5'b00000);
        step();
        idle();
        checks++;
        if (bus.set_addr !== 1'b1 || bus.in_addr !== 15'h0200) begin
            errors++;
            $display("FAIL after_flush got set_addr %b in_addr %h exp 1 0200", bus.set_addr, bus.in_addr);
        end
        step();
        step();
        step();
    endtask

    task automatic test_reset_mid_flush();
        drive(1'b1, 16'h4E83, 15'h0040, 16'h8123, 5'b00000);
        step();
        idle();
        step();
        checks++;
        if (dbg_state !== 2'd2) begin
            errors++;
            $display("FAIL pre_reset_state got %0d exp 2", dbg_state);
        end
        #1 CLR_N = 1'b0;
        #1;
        checks++;
        if ({bus.set_addr, bus.flush, bus.link_we} !== 3'b000 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL async_reset_strobes got %b state %0d exp 000 0", {bus.set_addr, bus.flush, bus.link_we}, dbg_state);
        end
        checks++;
        if ({bus.in_addr, bus.link_sel, bus.link_data} !== 34'h0) begin
            errors++;
            $display("FAIL async_reset_fields got %h exp 0", {bus.in_addr, bus.link_sel, bus.link_data});
        end
        step();
        CLR_N = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if (dbg_state !== 2'd0 || bus.set_addr !== 1'b0 || bus.flush !== 1'b0) begin
                errors++;
                $display("FAIL post_reset cyc %0d got state %0d set_addr %b flush %b exp 0 0 0", k, dbg_state, bus.set_addr, bus.flush);
            end
        end
    endtask

    initial begin
        test_reset();
        test_beq_taken();
        test_beq_not_taken();
        test_wrap();
        test_jal();
        test_conditions();
        test_back_to_back();
        test_reset_mid_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
